pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Hazard and sequencing controller for the 5-stage MIPS pipeline. Drives PC write-enable,
//  IF/ID write-enable/flush and ID/EX bubble from ID-stage register use, the EX-stage load,
//  the EX-stage taken-branch flag and a multi-cycle mult/div unit. Tracks mult/div occupancy
//  with an FSM + countdown; stalls HI/LO readers and new mult/div issues until the result is ready.
// PARAMETERS
//  MD_LAT  32  mult/div latency in cycles from issue to HI/LO valid (>=2)
//  CNT_W    6  countdown width; must satisfy 2**CNT_W > MD_LAT
// PORTS
//  clk            in   1  clock, rising edge
//  rst            in   1  reset, synchronous, active-high
//  id_rs          in   5  rs field of instruction in ID
//  id_rt          in   5  rt field of instruction in ID
//  id_uses_rt     in   1  ID instruction reads rt as source
//  id_md_start    in   1  ID instruction is mult/multu/div/divu
//  id_reads_hilo  in   1  ID instruction is mfhi/mflo
//  ex_memread     in   1  instruction in EX is a load
//  ex_rt          in   5  destination rt of the load in EX
//  ex_br_taken    in   1  branch/jump in EX resolved taken
//  pc_we          out  1  PC register write enable
//  ifid_we        out  1  IF/ID register write enable (0 = hold)
//  ifid_flush     out  1  IF/ID synchronous clear (same effect as rst on IF/ID)
//  idex_bubble    out  1  load NOP control into ID/EX
//  md_issue       out  1  pulse: mult/div accepted into unit this cycle
//  md_busy        out  1  mult/div result not yet valid
//  md_done        out  1  one-cycle pulse: HI/LO valid from next cycle
// BEHAVIOUR
//  - Outputs combinational from state+inputs; state/counter registered on posedge clk.
//  - rst=1: state<=MD_IDLE, cnt<=0; outputs that cycle: pc_we=0, ifid_we=0, ifid_flush=1,
//    idex_bubble=1, md_issue=0, md_busy=0, md_done=0. Reset mid-countdown aborts it.
//  - load_use = ex_memread & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
//  - md_hold = (id_reads_hilo | id_md_start) & state!=MD_IDLE.
//  - Priority (rst excluded): ex_br_taken > md_hold > load_use > normal.
//    br_taken: pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1; any ID md_start is killed.
//    md_hold / load_use: pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=1 (1-cycle per eval).
//    normal: pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0.
//  - md_issue = id_md_start & state==MD_IDLE & ~ex_br_taken & ~load_use.
//  - FSM: MD_IDLE --md_issue--> MD_BUSY, cnt<=MD_LAT-1.
//    MD_BUSY: cnt<=cnt-1; when cnt==1 -> MD_DONE.  MD_DONE -> MD_IDLE (1 cycle).
//  - md_busy=1 in MD_BUSY and MD_DONE; md_done=1 only in MD_DONE.
//  - HI/LO reader stalls through MD_DONE, proceeds in first MD_IDLE cycle: issue at cycle T,
//    reader in ID at T+1 advances at T+MD_LAT+1.
//  - Load-use stall is exactly one cycle: next cycle the load is in MEM, ex_memread=0.
//  - ex_rt==0 never stalls. Branch flush during MD_BUSY does not abort the unit.
// STRUCTURE
//  - Shared pkg pipe_ctrl_pkg: md_state_t {MD_IDLE=2'd0, MD_BUSY=2'd1, MD_DONE=2'd2},
//    REG_ZERO=5'd0; reused by the mult/div unit and the pipeline top.
//  - One sub-module natural: md_tracker (FSM + countdown, md_issue in, md_busy/md_done out).
//  - Hazard priority mux stays in pipe_hazard_ctrl; no other state.
// TESTING
//  1 rst=1 two cycles mid-MD_BUSY -> ifid_flush=1, idex_bubble=1, pc_we=0; then md_busy=0.
//  2 ex_memread=1, ex_rt=8, id_rs=8 -> pc_we=0, ifid_we=0, idex_bubble=1 one cycle only.
//  3 ex_memread=1, ex_rt=0, id_rs=0 -> no stall; ex_rt=9, id_rt=9, id_uses_rt=0 -> no stall.
//  4 ex_br_taken=1 with load_use=1 -> ifid_flush=1, pc_we=1, idex_bubble=1 (branch wins).
//  5 MD_LAT=4: md_start at T, mflo in ID at T+1 -> stalled T+1..T+4, md_done at T+4, go T+5.
//  6 md_start with ex_br_taken=1 -> md_issue=0, state stays MD_IDLE; 2nd md_start when busy stalls.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: mult/div occupancy states and register constants.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W = 5;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX observation fields in, pipeline enables out.
interface pipe_hazard_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             id_md_start;
    logic             id_reads_hilo;
    logic             ex_memread;
    logic [REG_W-1:0] ex_rt;
    logic             ex_br_taken;

    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             md_issue;
    logic             md_busy;
    logic             md_done;

    // Pipeline datapath side: presents the stage fields, consumes the enables.
    modport master (
        output id_rs, id_rt, id_uses_rt, id_md_start, id_reads_hilo,
               ex_memread, ex_rt, ex_br_taken,
        input  pc_we, ifid_we, ifid_flush, idex_bubble,
               md_issue, md_busy, md_done
    );

    // Controller side.
    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_md_start, id_reads_hilo,
               ex_memread, ex_rt, ex_br_taken,
        output pc_we, ifid_we, ifid_flush, idex_bubble,
               md_issue, md_busy, md_done
    );

endinterface

// File: rtl/pipe_hazard_ctrl_md_tracker.sv
// Mult/div occupancy tracker: counts down the unit latency after each accepted issue.
module md_tracker
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MD_LAT = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      md_issue,
    output md_state_t state,
    output logic      md_busy,
    output logic      md_done
);

    logic [CNT_W-1:0] cnt;

    // Occupancy FSM: IDLE -> BUSY for MD_LAT-1 cycles -> DONE for one cycle -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (md_issue) begin
                        state <= MD_BUSY;
                        cnt   <= CNT_W'(MD_LAT - 1);
                    end
                end
                MD_BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    state <= MD_IDLE;
                end
                default: begin
                    state <= MD_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // HI/LO is unusable until the unit returns to IDLE; DONE flags the last such cycle.
    assign md_busy = (state == MD_BUSY) || (state == MD_DONE);
    assign md_done = (state == MD_DONE);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: branch flush,
// load-use stall, HI/LO / mult-div occupancy stall and mult/div issue.
module pipe_hazard_ctrl #(
    parameter int unsigned MD_LAT = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);
    import pipe_ctrl_pkg::*;

    md_state_t md_state;
    logic      trk_busy;
    logic      trk_done;
    logic      load_use;
    logic      md_hold;
    logic      issue;
    logic      pc_we;
    logic      ifid_we;
    logic      ifid_flush;
    logic      idex_bubble;

    md_tracker #(
        .MD_LAT (MD_LAT),
        .CNT_W  (CNT_W)
    ) u_md_tracker (
        .clk      (clk),
        .rst      (rst),
        .md_issue (issue),
        .state    (md_state),
        .md_busy  (trk_busy),
        .md_done  (trk_done)
    );

    // Hazard detection and priority mux: reset > taken branch > md hold / load-use > normal.
    always_comb begin
        load_use = bus.ex_memread && (bus.ex_rt != REG_ZERO) &&
                   ((bus.ex_rt == bus.id_rs) ||
                    (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
        md_hold  = (bus.id_reads_hilo || bus.id_md_start) && (md_state != MD_IDLE);
        issue    = !rst && bus.id_md_start && (md_state == MD_IDLE) &&
                   !bus.ex_br_taken && !load_use;

        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;

        if (rst) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (bus.ex_br_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (md_hold || load_use) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    assign bus.pc_we       = pc_we;
    assign bus.ifid_we     = ifid_we;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.md_issue    = issue;
    assign bus.md_busy     = !rst && trk_busy;
    assign bus.md_done     = !rst && trk_done;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vectors with literal expectations plus a
// per-cycle comparison against a cycle-window model of the mult/div unit.
module tb_pipe_hazard_ctrl;

    localparam int MD_LAT = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(
        .MD_LAT (MD_LAT),
        .CNT_W  (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic mds, input logic hilo, input logic mr,
                       input logic [4:0] ert, input logic br);
        bus.id_rs         = rs;
        bus.id_rt         = rt;
        bus.id_uses_rt    = urt;
        bus.id_md_start   = mds;
        bus.id_reads_hilo = hilo;
        bus.ex_memread    = mr;
        bus.ex_rt         = ert;
        bus.ex_br_taken   = br;
        #2;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Literal check of the four pipeline enables.
    task automatic ctl(input string nm, input logic pc, input logic we,
                       input logic fl, input logic bb);
        chk({nm, "_pc_we"},       bus.pc_we,       pc);
        chk({nm, "_ifid_we"},     bus.ifid_we,     we);
        chk({nm, "_ifid_flush"},  bus.ifid_flush,  fl);
        chk({nm, "_idex_bubble"}, bus.idex_bubble, bb);
    endtask

    // Model: the unit is busy on the MD_LAT cycles after the issue cycle, done on the last.
    int cyc       = 0;
    int issue_cyc = -1;

    initial begin
        logic lu, busy, done, hold, e_pc, e_we, e_fl, e_bb, e_iss;
        forever begin
            @(negedge clk);
            lu   = bus.ex_memread && (bus.ex_rt != 5'd0) &&
                   ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
            busy = (issue_cyc >= 0) && (cyc > issue_cyc) && (cyc <= issue_cyc + MD_LAT);
            done = (issue_cyc >= 0) && (cyc == issue_cyc + MD_LAT);
            hold = (bus.id_reads_hilo || bus.id_md_start) && busy;
            if (rst) begin
                {e_pc, e_we, e_fl, e_bb} = 4'b0011;
                busy = 1'b0;
                done = 1'b0;
            end else if (bus.ex_br_taken) begin
                {e_pc, e_we, e_fl, e_bb} = 4'b1111;
            end else if (hold || lu) begin
                {e_pc, e_we, e_fl, e_bb} = 4'b0001;
            end else begin
                {e_pc, e_we, e_fl, e_bb} = 4'b1100;
            end
            e_iss = !rst && bus.id_md_start && !busy && !bus.ex_br_taken && !lu;
            chk("model_pc_we",       bus.pc_we,       e_pc);
            chk("model_ifid_we",     bus.ifid_we,     e_we);
            chk("model_ifid_flush",  bus.ifid_flush,  e_fl);
            chk("model_idex_bubble", bus.idex_bubble, e_bb);
            chk("model_md_issue",    bus.md_issue,    e_iss);
            chk("model_md_busy",     bus.md_busy,     busy);
            chk("model_md_done",     bus.md_done,     done);
            @(posedge clk);
            if (rst)        issue_cyc = -1;
            else if (e_iss) issue_cyc = cyc;
            cyc++;
        end
    end

    initial begin
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        nxt();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        ctl("reset", 0, 0, 1, 1);
        chk("reset_md_busy", bus.md_busy, 0);
        nxt();
        rst = 1'b0;

        // Normal flow.
        drv(1, 2, 1, 0, 0, 0, 0, 0);
        ctl("normal", 1, 1, 0, 0);
        nxt();

        // Load-use on rs stalls exactly one cycle.
        drv(8, 2, 1, 0, 0, 1, 8, 0);
        ctl("lu_rs", 0, 0, 0, 1);
        nxt();
        drv(8, 2, 1, 0, 0, 0, 8, 0);
        ctl("lu_rs_after", 1, 1, 0, 0);
        nxt();

        // Load-use via rt when rt is a source.
        drv(3, 8, 1, 0, 0, 1, 8, 0);
        ctl("lu_rt", 0, 0, 0, 1);
        nxt();

        // $zero destination never stalls; unused rt never stalls.
        drv(0, 0, 1, 0, 0, 1, 0, 0);
        ctl("lu_r0", 1, 1, 0, 0);
        nxt();
        drv(1, 9, 0, 0, 0, 1, 9, 0);
        ctl("lu_rt_unused", 1, 1, 0, 0);
        nxt();

        // Taken branch beats a simultaneous load-use.
        drv(8, 2, 1, 0, 0, 1, 8, 1);
        ctl("br_over_lu", 1, 1, 1, 1);
        nxt();

        // mult/div start killed by a taken branch stays idle.
        drv(1, 2, 1, 1, 0, 0, 0, 1);
        chk("md_br_issue", bus.md_issue, 0);
        nxt();
        drv(1, 2, 0, 0, 0, 0, 0, 0);
        chk("md_br_busy", bus.md_busy, 0);
        nxt();

        // mult/div start blocked by a load-use hazard.
        drv(8, 2, 1, 1, 0, 1, 8, 0);
        chk("md_lu_issue", bus.md_issue, 0);
        ctl("md_lu", 0, 0, 0, 1);
        nxt();

        // Issue at T, mflo from T+1: stalled T+1..T+4, done at T+4, proceeds at T+5.
        drv(4, 5, 1, 1, 0, 0, 0, 0);
        chk("md_T_issue", bus.md_issue, 1);
        chk("md_T_busy", bus.md_busy, 0);
        nxt();
        for (int i = 1; i <= MD_LAT; i++) begin
            drv(0, 0, 0, 0, 1, 0, 0, 0);
            ctl("mflo_wait", 0, 0, 0, 1);
            chk("mflo_wait_busy", bus.md_busy, 1);
            chk("mflo_wait_done", bus.md_done, (i == MD_LAT) ? 1'b1 : 1'b0);
            nxt();
        end
        drv(0, 0, 0, 0, 1, 0, 0, 0);
        ctl("mflo_go", 1, 1, 0, 0);
        chk("mflo_go_busy", bus.md_busy, 0);
        nxt();

        // Second start while busy stalls; branch in BUSY does not abort; reset does.
        drv(4, 5, 1, 1, 0, 0, 0, 0);
        chk("md2_issue", bus.md_issue, 1);
        nxt();
        drv(4, 5, 1, 1, 0, 0, 0, 0);
        chk("md2_again_issue", bus.md_issue, 0);
        ctl("md2_again", 0, 0, 0, 1);
        nxt();
        drv(1, 2, 0, 0, 0, 0, 0, 1);
        ctl("md2_br", 1, 1, 1, 1);
        chk("md2_br_busy", bus.md_busy, 1);
        nxt();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drv(4, 5, 1, 1, 0, 0, 0, 0);
            ctl("mid_rst", 0, 0, 1, 1);
            chk("mid_rst_busy", bus.md_busy, 0);
            chk("mid_rst_issue", bus.md_issue, 0);
            nxt();
        end
        rst = 1'b0;
        drv(1, 2, 0, 0, 0, 0, 0, 0);
        chk("post_rst_busy", bus.md_busy, 0);
        chk("post_rst_done", bus.md_done, 0);
        ctl("post_rst", 1, 1, 0, 0);
        nxt();

        // Start held back-to-back: second one issues on the first idle cycle.
        drv(4, 5, 1, 1, 0, 0, 0, 0);
        chk("md3_issue", bus.md_issue, 1);
        nxt();
        for (int i = 1; i <= MD_LAT; i++) begin
            drv(4, 5, 1, 1, 0, 0, 0, 0);
            chk("md3_hold_issue", bus.md_issue, 0);
            nxt();
        end
        drv(4, 5, 1, 1, 0, 0, 0, 0);
        chk("md3_reissue", bus.md_issue, 1);
        nxt();
        for (int i = 0; i < MD_LAT + 2; i++) begin
            drv(3, 6, 1, 0, 0, 0, 0, 0);
            nxt();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
